io_port: RTL and testbench
==========================

// Module: io_port
// PURPOSE
//  CPU-side I/O responder for the IOR/IOW path driven by the control unit.
//  Decodes iom/wen strobes plus an address into two registers: DATA and STATUS.
//  DATA writes are sent out on a valid/ready TX stream through a 1-entry holding register.
//  RX stream words are buffered in a small FIFO and popped by DATA reads.
//  Sits between the datapath bus (address, write data, read data) and the external peripherals.
// PARAMETERS
//  DW        16       data width of CPU bus and both streams
//  RX_DEPTH  4        RX FIFO entries; power of 2, range 2..128
//  DATA_ADDR 16'h0000 address of DATA register
//  STAT_ADDR 16'h0001 address of STATUS register
// PORTS
//  clk       in   1   clock; all state updates on rising edge
//  rst       in   1   reset, synchronous, active-high
//  iom_in    in   1   I/O access strobe from control unit
//  wen_in    in   1   0 = write, 1 = read (active-low write, same as control unit wen)
//  addr_in   in   16  register address
//  wdata_in  in   DW  CPU write data
//  rdata_out out  DW  CPU read data (combinational)
//  tx_data   out  DW  outbound word
//  tx_valid  out  1   outbound word valid
//  tx_ready  in   1   sink accepts when tx_valid && tx_ready
//  rx_data   in   DW  inbound word
//  rx_valid  in   1   inbound word valid
//  rx_ready  out  1   FIFO can accept
// BEHAVIOUR
//  Access decode: wr = iom_in && !wen_in; rd = iom_in && wen_in. Each access takes one cycle, with no wait states.
//  Reset: tx_valid=0, tx_data=0, tx_drop=0, FIFO empty (count=0), rx_ready=0 while rst=1.
//  rdata_out: 0 when !rd or the address is unmapped.
//   DATA read: FIFO head, or 0 if empty.
//   STATUS read: {count[7:0], 4'b0, tx_drop, tx_valid, full, !empty}. Bit0 = nonempty.
//  DATA read while nonempty: pop at the edge; the head advances next cycle. A read while empty does not pop.
//  rx_ready = !full && !rst. Push when rx_valid && rx_ready. There is no bypass when full, even if a pop occurs in the same cycle.
//  Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
//  Pointers wrap modulo RX_DEPTH. count is $clog2(RX_DEPTH)+1 bits, zero-extended into the status field.
//  TX holding register:
//   DATA write with !tx_valid: tx_data<=wdata_in, tx_valid<=1.
//   DATA write with tx_valid && tx_ready: handshake completes and the new word loads; tx_valid stays 1.
//   DATA write with tx_valid && !tx_ready: write dropped, tx_data held, tx_drop<=1.
//   No write, tx_valid && tx_ready: tx_valid<=0.
//  tx_data is stable while tx_valid && !tx_ready.
//  STATUS write: wdata_in[3]=1 clears tx_drop. If a set and a clear occur in the same cycle, the set wins. Other bits are ignored.
//  Writes to unmapped addresses are ignored. Reads of unmapped addresses return 0 with no side effects.
//  Reset asserted mid-transfer: TX word discarded, FIFO contents lost, and no handshake completes in that cycle.
// STRUCTURE
//  mycpu_pkg additions:
//   io_reg_t enum {IO_DATA, IO_STAT, IO_NONE}
//   bit-index constants IO_ST_NEMPTY=0, IO_ST_FULL=1, IO_ST_TXBUSY=2, IO_ST_TXDROP=3
//  Sub-module io_rx_fifo (DW, RX_DEPTH):
//   ports: push/pop/din/dout/full/empty/count
//   storage in a register array with rd/wr pointers
//  io_port top: address decode, TX holding register, tx_drop flag, read mux.
// TESTING
//  Reset: hold rst 2 cycles -> tx_valid=0, rx_ready=0; after release rx_ready=1; STATUS read = 16'h0000.
//  TX: write DATA=16'hA5A5 with tx_ready=0 -> next cycle tx_valid=1, tx_data=A5A5.
//   Second write 16'h1234 -> dropped, tx_data=A5A5, STATUS bit3=1.
//   Then tx_ready=1 -> tx_valid=0 the following cycle.
//  Drop clear: STATUS write 16'h0008 -> bit3=0.
//   Same-cycle new drop and clear -> bit3 stays 1.
//  RX fill: push 1,2,3,4 with RX_DEPTH=4 -> rx_ready=0, STATUS=16'h0403; rx_valid held for word 5 -> not accepted.
//   Four DATA reads return 1,2,3,4; a fifth read returns 0 with count 0.
//  Simultaneous: count=2, push 7 and DATA read in the same cycle -> read returns the old head, count stays 2, 7 is read last.
//   Pointer wrap verified over 10 words.
//  Back-to-back TX: tx_ready=1 constant, DATA writes every cycle 1..5 -> sink receives 1..5 in order, no drops.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared register selectors and STATUS bit positions for the CPU I/O port.
package io_port_pkg;

    typedef enum logic [1:0] {
        IO_DATA,
        IO_STAT,
        IO_NONE
    } io_reg_t;

    localparam int IO_ST_NEMPTY = 0;
    localparam int IO_ST_FULL   = 1;
    localparam int IO_ST_TXBUSY = 2;
    localparam int IO_ST_TXDROP = 3;

    localparam int IO_ST_CNT_LSB = 8;
    localparam int IO_ST_WIDTH   = 16;

    function automatic io_reg_t io_decode(
        input logic [15:0] addr,
        input logic [15:0] data_addr,
        input logic [15:0] stat_addr
    );
        io_reg_t sel;
        if (addr == data_addr) begin
            sel = IO_DATA;
        end else if (addr == stat_addr) begin
            sel = IO_STAT;
        end else begin
            sel = IO_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// Small inbound FIFO: register array, wrapping pointers and an occupancy count.
module io_rx_fifo
    import io_port_pkg::*;
#(
    parameter int DW       = 16,
    parameter int RX_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DW-1:0]             din,
    output logic [DW-1:0]             dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(RX_DEPTH):0] count
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_reg [RX_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_reg == CW'(RX_DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign dout  = mem_reg[rd_ptr_reg];

    // No bypass: a push into a full FIFO is refused even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    assign wr_ptr_next = do_push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    assign rd_ptr_next = do_pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

endmodule

// File: rtl/io_port.sv
// CPU I/O responder: decodes DATA/STATUS accesses, drives a TX holding register
// and drains an RX FIFO on DATA reads.
module io_port
    import io_port_pkg::*;
#(
    parameter int          DW        = 16,
    parameter int          RX_DEPTH  = 4,
    parameter logic [15:0] DATA_ADDR = 16'h0000,
    parameter logic [15:0] STAT_ADDR = 16'h0001
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iom_in,
    input  logic          wen_in,
    input  logic [15:0]   addr_in,
    input  logic [DW-1:0] wdata_in,
    output logic [DW-1:0] rdata_out,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready
);

    localparam int CW = $clog2(RX_DEPTH) + 1;

    io_reg_t       sel;
    logic          wr;
    logic          rd;
    logic          data_wr;
    logic          stat_wr;
    logic          data_rd;
    logic          stat_rd;

    logic          fifo_push;
    logic          fifo_pop;
    logic [DW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic [DW-1:0] tx_data_reg;
    logic          tx_valid_reg;
    logic          tx_drop_reg;
    logic          tx_load;
    logic          drop_set;
    logic          drop_clr;

    logic [IO_ST_WIDTH-1:0] status_word;

    // wen_in is the control unit's active-low write strobe.
    assign wr  = iom_in && !wen_in;
    assign rd  = iom_in &&  wen_in;
    assign sel = io_decode(addr_in, DATA_ADDR, STAT_ADDR);

    assign data_wr = wr && (sel == IO_DATA);
    assign stat_wr = wr && (sel == IO_STAT);
    assign data_rd = rd && (sel == IO_DATA);
    assign stat_rd = rd && (sel == IO_STAT);

    assign rx_ready  = !fifo_full && !rst;
    assign fifo_push = rx_valid && rx_ready;
    assign fifo_pop  = data_rd && !fifo_empty;

    io_rx_fifo #(
        .DW       (DW),
        .RX_DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A DATA write is accepted when the holding register is free or drains this cycle.
    assign tx_load  = data_wr && (!tx_valid_reg || tx_ready);
    assign drop_set = data_wr && tx_valid_reg && !tx_ready;
    assign drop_clr = stat_wr && wdata_in[IO_ST_TXDROP];

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
            tx_drop_reg  <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_data_reg  <= wdata_in;
                tx_valid_reg <= 1'b1;
            end else if (!data_wr && tx_valid_reg && tx_ready) begin
                tx_valid_reg <= 1'b0;
            end

            // A new drop outranks a clear in the same cycle.
            if (drop_set) begin
                tx_drop_reg <= 1'b1;
            end else if (drop_clr) begin
                tx_drop_reg <= 1'b0;
            end
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;

    always_comb begin
        status_word                = '0;
        status_word[15:8]          = 8'(fifo_count);
        status_word[IO_ST_NEMPTY]  = !fifo_empty;
        status_word[IO_ST_FULL]    = fifo_full;
        status_word[IO_ST_TXBUSY]  = tx_valid_reg;
        status_word[IO_ST_TXDROP]  = tx_drop_reg;
    end

    always_comb begin
        rdata_out = '0;
        if (data_rd) begin
            rdata_out = fifo_empty ? '0 : fifo_dout;
        end else if (stat_rd) begin
            rdata_out = DW'(status_word);
        end
    end

endmodule

// File: tb/tb_io_port.sv
// Self-checking bench for io_port: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_io_port;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          iom_in;
    logic          wen_in;
    logic [15:0]   addr_in;
    logic [DW-1:0] wdata_in;
    logic [DW-1:0] rdata_out;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_q[$];
    logic [15:0] sink_q[$];
    logic        m_tx_valid;
    logic [15:0] m_tx_data;
    logic        m_drop;

    io_port #(
        .DW       (DW),
        .RX_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iom_in    (iom_in),
        .wen_in    (wen_in),
        .addr_in   (addr_in),
        .wdata_in  (wdata_in),
        .rdata_out (rdata_out),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s        = '0;
        s[15:8]  = 8'(m_q.size());
        s[3]     = m_drop;
        s[2]     = m_tx_valid;
        s[1]     = (m_q.size() == DEPTH);
        s[0]     = (m_q.size() != 0);
        return s;
    endfunction

    function automatic logic [15:0] m_rdata();
        if (!(iom_in && wen_in)) return 16'h0;
        if (addr_in == 16'h0000) return (m_q.size() != 0) ? m_q[0] : 16'h0;
        if (addr_in == 16'h0001) return m_status();
        return 16'h0;
    endfunction

    // Advance one clock: update the model from the spec rules, record sink handshakes.
    task automatic tick();
        logic        wr, rd, push, pop, rdy, r;
        logic [15:0] wd, a, rxd;
        wr   = iom_in && !wen_in;
        rd   = iom_in && wen_in;
        a    = addr_in;
        wd   = wdata_in;
        rdy  = tx_ready;
        rxd  = rx_data;
        r    = rst;
        push = rx_valid && !r && (m_q.size() < DEPTH);
        pop  = rd && (a == 16'h0000) && (m_q.size() != 0);
        if (!r && tx_valid && tx_ready) sink_q.push_back(tx_data);
        @(posedge clk);
        #1;
        if (r) begin
            m_q.delete();
            m_tx_valid = 1'b0;
            m_tx_data  = 16'h0;
            m_drop     = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(rxd);
            if (wr && a == 16'h0000) begin
                if (!m_tx_valid || rdy) begin
                    m_tx_data  = wd;
                    m_tx_valid = 1'b1;
                end else begin
                    m_drop = 1'b1;
                end
            end else begin
                if (m_tx_valid && rdy) m_tx_valid = 1'b0;
                if (wr && a == 16'h0001 && wd[3]) m_drop = 1'b0;
            end
        end
    endtask

    task automatic bus_idle();
        iom_in   = 1'b0;
        wen_in   = 1'b1;
        addr_in  = 16'h0;
        wdata_in = 16'h0;
    endtask

    task automatic read_reg(input logic [15:0] a, output logic [15:0] d);
        iom_in  = 1'b1;
        wen_in  = 1'b1;
        addr_in = a;
        #1;
        d = rdata_out;
        $display("rd  addr=%h data=%h", a, d);
        tick();
        bus_idle();
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [15:0] d);
        iom_in   = 1'b1;
        wen_in   = 1'b0;
        addr_in  = a;
        wdata_in = d;
        $display("wr  addr=%h data=%h", a, d);
        tick();
        bus_idle();
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst = 1'b1;
        tick();
        tick();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
        total++; if (tx_data !== 16'h0) begin bad++; $display("FAIL reset_tx_data got=%h exp=0000", tx_data); end
        rst = 1'b0;
        #1;
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL release_rx_ready got=%b exp=1", rx_ready); end
        read_reg(16'h0001, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_status got=%h exp=0000", d); end
    endtask

    task automatic test_tx();
        logic [15:0] d;
        tx_ready = 1'b0;
        write_reg(16'h0000, 16'hA5A5);
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL tx_load_valid got=%b exp=1", tx_valid); end
        total++; if (tx_data !== 16'hA5A5) begin bad++; $display("FAIL tx_load_data got=%h exp=a5a5", tx_data); end
        write_reg(16'h0000, 16'h1234);
        total++; if (tx_data !== 16'hA5A5) begin bad++; $display("FAIL tx_drop_hold got=%h exp=a5a5", tx_data); end
        read_reg(16'h0001, d);
        total++; if (d[3] !== 1'b1) begin bad++; $display("FAIL tx_drop_flag got=%b exp=1", d[3]); end
        total++; if (d[2] !== 1'b1) begin bad++; $display("FAIL tx_busy_flag got=%b exp=1", d[2]); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drain got=%b exp=0", tx_valid); end
    endtask

    task automatic test_drop_clear();
        logic [15:0] d;
        write_reg(16'h0001, 16'h0008);
        read_reg(16'h0001, d);
        total++; if (d[3] !== 1'b0) begin bad++; $display("FAIL drop_clear got=%b exp=0", d[3]); end
        tx_ready = 1'b0;
        write_reg(16'h0000, 16'h1111);
        write_reg(16'h0000, 16'h2222);
        total++; if (tx_data !== 16'h1111) begin bad++; $display("FAIL drop2_hold got=%h exp=1111", tx_data); end
        write_reg(16'h0001, 16'hFFF7);
        read_reg(16'h0001, d);
        total++; if (d[3] !== 1'b1) begin bad++; $display("FAIL drop_other_bits got=%b exp=1", d[3]); end
        write_reg(16'h0001, 16'h0008);
        write_reg(16'h0000, 16'h3333);
        read_reg(16'h0001, d);
        total++; if (d[3] !== 1'b1) begin bad++; $display("FAIL drop_reset_after_clear got=%b exp=1", d[3]); end
        write_reg(16'h0001, 16'h0008);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        read_reg(16'h0001, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL drop_final_status got=%h exp=0000", d); end
    endtask

    task automatic test_rx_fill();
        logic [15:0] d;
        for (int i = 1; i <= 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = 16'(i);
            $display("rx  push data=%h", rx_data);
            tick();
        end
        rx_data = 16'h0005;
        #1;
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL fill_rx_ready got=%b exp=0", rx_ready); end
        tick();
        tick();
        rx_valid = 1'b0;
        read_reg(16'h0001, d);
        total++; if (d !== 16'h0403) begin bad++; $display("FAIL fill_status got=%h exp=0403", d); end
        for (int i = 1; i <= 4; i++) begin
            read_reg(16'h0000, d);
            total++; if (d !== 16'(i)) begin bad++; $display("FAIL drain_word%0d got=%h exp=%h", i, d, 16'(i)); end
        end
        read_reg(16'h0000, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL empty_read got=%h exp=0000", d); end
        read_reg(16'h0001, d);
        total++; if (d[15:8] !== 8'h00) begin bad++; $display("FAIL empty_count got=%h exp=00", d[15:8]); end
    endtask

    task automatic test_simultaneous();
        logic [15:0] d;
        rx_valid = 1'b1;
        rx_data  = 16'h000A;
        tick();
        rx_data  = 16'h000B;
        tick();
        rx_data  = 16'h0007;
        iom_in   = 1'b1;
        wen_in   = 1'b1;
        addr_in  = 16'h0000;
        #1;
        d = rdata_out;
        $display("rd  addr=0000 data=%h (with push 0007)", d);
        tick();
        rx_valid = 1'b0;
        bus_idle();
        total++; if (d !== 16'h000A) begin bad++; $display("FAIL simul_old_head got=%h exp=000a", d); end
        read_reg(16'h0001, d);
        total++; if (d[15:8] !== 8'h02) begin bad++; $display("FAIL simul_count got=%h exp=02", d[15:8]); end
        read_reg(16'h0000, d);
        total++; if (d !== 16'h000B) begin bad++; $display("FAIL simul_second got=%h exp=000b", d); end
        read_reg(16'h0000, d);
        total++; if (d !== 16'h0007) begin bad++; $display("FAIL simul_last got=%h exp=0007", d); end
    endtask

    task automatic test_wrap();
        logic [15:0] d;
        logic [15:0] exp_q[$];
        for (int i = 0; i < 10; i++) begin
            rx_valid = 1'b1;
            rx_data  = 16'(16'h0100 + i);
            exp_q.push_back(rx_data);
            tick();
            rx_valid = 1'b0;
            if (i % 2 == 1) begin
                for (int k = 0; k < 2; k++) begin
                    read_reg(16'h0000, d);
                    total++; if (d !== exp_q[0]) begin bad++; $display("FAIL wrap_word got=%h exp=%h", d, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
        end
        read_reg(16'h0001, d);
        total++; if (d !== m_status()) begin bad++; $display("FAIL wrap_status got=%h exp=%h", d, m_status()); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        sink_q.delete();
        tx_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            iom_in   = 1'b1;
            wen_in   = 1'b0;
            addr_in  = 16'h0000;
            wdata_in = 16'(i);
            $display("wr  addr=0000 data=%h (back-to-back)", wdata_in);
            tick();
        end
        bus_idle();
        tick();
        tick();
        tx_ready = 1'b0;
        total++; if (sink_q.size() !== 5) begin bad++; $display("FAIL b2b_count got=%0d exp=5", sink_q.size()); end
        for (int i = 0; i < 5 && i < sink_q.size(); i++) begin
            total++; if (sink_q[i] !== 16'(i + 1)) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i, sink_q[i], 16'(i + 1)); end
        end
        read_reg(16'h0001, d);
        total++; if (d[3] !== 1'b0) begin bad++; $display("FAIL b2b_no_drop got=%b exp=0", d[3]); end
    endtask

    task automatic test_random();
        logic [15:0] exp_rd;
        int sel;
        for (int n = 0; n < 300; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            iom_in   = ($urandom_range(0, 2) != 0);
            wen_in   = $urandom_range(0, 1);
            sel      = $urandom_range(0, 5);
            addr_in  = (sel < 3) ? 16'h0000 : (sel < 5) ? 16'h0001 : 16'($urandom_range(2, 65535));
            wdata_in = 16'($urandom);
            tx_ready = $urandom_range(0, 1);
            rx_valid = $urandom_range(0, 1);
            rx_data  = 16'($urandom);
            #1;
            exp_rd = m_rdata();
            $display("rnd n=%0d rst=%b iom=%b wen=%b addr=%h rdata=%h txv=%b txd=%h rxr=%b",
                     n, rst, iom_in, wen_in, addr_in, rdata_out, tx_valid, tx_data, rx_ready);
            total++; if (rdata_out !== exp_rd) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, rdata_out, exp_rd); end
            total++; if (tx_valid !== m_tx_valid) begin bad++; $display("FAIL rnd_tx_valid n=%0d got=%b exp=%b", n, tx_valid, m_tx_valid); end
            total++; if (tx_valid && tx_data !== m_tx_data) begin bad++; $display("FAIL rnd_tx_data n=%0d got=%h exp=%h", n, tx_data, m_tx_data); end
            total++; if (rx_ready !== (!rst && m_q.size() < DEPTH)) begin bad++; $display("FAIL rnd_rx_ready n=%0d got=%b exp=%b", n, rx_ready, (!rst && m_q.size() < DEPTH)); end
            tick();
        end
        rst      = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        bus_idle();
    endtask

    initial begin
        rst      = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 16'h0;
        bus_idle();
        m_tx_valid = 1'b0;
        m_tx_data  = 16'h0;
        m_drop     = 1'b0;
        #2;
        test_reset();
        test_tx();
        test_drop_clear();
        test_rx_fill();
        test_simultaneous();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
